// File: rtl/eu_dispatch_if.sv
// Bundle between fetch/decode, the dispatcher and the EU.
// Handshakes: a word moves on a rising clk edge where ir_valid & ir_ready are
// both high; ir_valid may rise at any time and ir_ready never depends on it.
interface eu_dispatch_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   ir_in;
  logic          ir_valid;
  logic          ir_ready;
  logic          flush;
  logic          eu_ready;
  logic [31:0]   ir;
  logic [1:0]    sel_eu;
  logic          cs;
  logic          busy;
  logic [CW-1:0] count;
  logic          illegal;
  logic          err;
  logic [1:0]    dbg_state;  // 0 IDLE, 1 ISSUE, 2 WAIT_BUSY, 3 WAIT_DONE

  modport slave (
    input  ir_in, ir_valid, flush, eu_ready,
    output ir_ready, ir, sel_eu, cs, busy, count, illegal, err, dbg_state
  );

  modport master (
    output ir_in, ir_valid, flush, eu_ready,
    input  ir_ready, ir, sel_eu, cs, busy, count, illegal, err, dbg_state
  );
endinterface

// File: rtl/eu_dispatch.sv
// Queues decoded instruction words, classifies them and issues them one at a
// time to the EU with a single-cycle cs pulse, retiring on EU completion.
module eu_dispatch #(
  parameter int DEPTH   = 4,
  parameter int BUSY_TO = 4
) (
  input  logic         clk,
  input  logic         rst,
  eu_dispatch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TO + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [33:0]   mem_q [DEPTH];
  logic [33:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   ir_q, ir_d;
  logic [1:0]    sel_q, sel_d;
  logic          cs_q, cs_d;
  logic          busy_q, busy_d;
  logic          illegal_q, illegal_d;
  logic          err_q, err_d;

  logic [33:0]   head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          keep;

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // A flush cycle never accepts a word, even when there is room.
  assign push  = bus.ir_valid && !full && !bus.flush;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tmo_d     = tmo_q;
    ir_d      = ir_q;
    sel_d     = sel_q;
    cs_d      = 1'b0;
    illegal_d = 1'b0;
    err_d     = 1'b0;
    pop       = 1'b0;
    keep      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The head is only looked at when it is not being flushed away.
        if (!empty && !bus.flush) begin
          if (head[33:32] == 2'b11) begin
            pop       = 1'b1;
            illegal_d = 1'b1;
          end else if (bus.eu_ready) begin
            state_d = S_ISSUE;
            ir_d    = head[31:0];
            sel_d   = head[33:32];
            cs_d    = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
        tmo_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (!bus.eu_ready) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TO - 1)) begin
          pop     = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (bus.eu_ready) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    // Flush keeps only an in-flight head that is not retiring this cycle.
    if (bus.flush) begin
      keep     = (state_q != S_IDLE) && !pop;
      wr_ptr_d = rd_ptr_d + AW'(keep);
      count_d  = CW'(keep);
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {bus.ir_in[22:21], bus.ir_in};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tmo_q     <= '0;
      ir_q      <= '0;
      sel_q     <= '0;
      cs_q      <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tmo_q     <= tmo_d;
      ir_q      <= ir_d;
      sel_q     <= sel_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
    end
  end

  assign bus.ir_ready  = !full;
  assign bus.ir        = ir_q;
  assign bus.sel_eu    = sel_q;
  assign bus.cs        = cs_q;
  assign bus.busy      = busy_q;
  assign bus.count     = count_q;
  assign bus.illegal   = illegal_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;
endmodule

// File: doc/eu_dispatch.md
# eu_dispatch

Instruction dispatcher for the execution unit. Buffers decoded 32-bit instruction words from the fetch path in a small FIFO and classifies each one into the EU's `sel_eu` operation class. It issues one instruction at a time to the EU with a single-cycle `cs` pulse, holds `ir`/`sel_eu` stable until the EU reports completion on `ready1`, and only then retires the entry. Sits between the fetch/decode logic and `eu`, replacing direct driving of `cs`/`sel_eu`/`ir`.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- BUSY_TO, 4, cycles allowed for EU `ready1` to fall after `cs` before the issue is declared failed
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ir_in  in  32  instruction word from fetch
- ir_valid  in  1  `ir_in` valid; push occurs when `ir_valid & ir_ready`
- ir_ready  out  1  FIFO not full
- flush  in  1  discard all queued, not-yet-issued entries
- eu_ready  in  1  EU `ready1`
- ir  out  32  instruction word to EU, stable for the whole EU operation
- sel_eu  out  2  class to EU: 00 arith-immediate, 01 arith-register, 10 compare
- cs  out  1  EU start pulse, exactly one cycle per issued instruction
- busy  out  1  an instruction is in flight (FSM not IDLE)
- count  out  $clog2(DEPTH)+1  FIFO occupancy, including the in-flight entry
- illegal  out  1  one-cycle pulse when a class-11 word is dropped
- err  out  1  one-cycle pulse on BUSY_TO timeout

## Operation
- Class field is `ir_in[22:21]`. 00→`sel_eu`=00, 01→01, 10→10. 11 is illegal: the entry is popped at head without issue and `illegal` pulses.
- The FIFO stores {class, word}. The head entry remains in the FIFO until retired.
- FSM states:
  - IDLE: if FIFO is non-empty and the head is legal and `eu_ready`=1 → ISSUE. If the head is illegal → pop, pulse `illegal`, stay in IDLE.
  - ISSUE: `cs`=1 for this cycle only; `ir`/`sel_eu` are loaded from head on entry → WAIT_BUSY.
  - WAIT_BUSY: `eu_ready`=0 → WAIT_DONE. Otherwise count cycles; on reaching BUSY_TO → pop, pulse `err`, go to IDLE.
  - WAIT_DONE: `eu_ready`=1 → pop (retire), go to IDLE.
- `ir`/`sel_eu` registers change only on entry to ISSUE; they hold their value through IDLE afterwards.
- Push and pop in the same cycle: occupancy is unchanged and both take effect.
- When full, `ir_ready`=0 and `ir_valid` is ignored.
- `flush`:
  - Removes every entry except the in-flight head (when FSM ≠ IDLE). `count` becomes 1 if in flight, else 0.
  - A push in the same cycle as `flush` is discarded.
  - The in-flight instruction completes normally.
- `rst` takes priority over everything. The FIFO empties and the FSM goes to IDLE even mid-operation. The EU is not reset by this block.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: `ir`=0, `sel_eu`=00, `cs`=0, `busy`=0, `count`=0, `ir_ready`=1, `illegal`=0, `err`=0.
- All outputs are registered except `ir_ready`, which is decoded from `count`.
- Push at edge N: `count` is visible at N+1. The earliest ISSUE (`cs` high) is the cycle after N+1's IDLE evaluation, i.e. `cs` asserts 2 cycles after the push edge when idle.
- EU handshake: `ready1` is expected low within 1–2 cycles of `cs`. The BUSY_TO count starts in the first WAIT_BUSY cycle.
- Retire happens on the edge where `eu_ready`=1 is sampled in WAIT_DONE. The next `cs` is at the earliest 2 cycles later: IDLE, then ISSUE.
- Minimum issue-to-issue spacing is 4 cycles (ISSUE, ≥1 WAIT_BUSY, ≥1 WAIT_DONE, IDLE).
- An illegal head costs 1 IDLE cycle per entry.

## Test plan
- Reset then push one word with `ir_in[22:21]`=00 and `ir_in[15:0]`=0x0005:
  - `cs` pulses once.
  - `sel_eu`=00 and `ir` equals the word for the whole operation.
  - `count` goes 1→0 on the `eu_ready` rise.
- Push classes 01, 10, 11, 00 back to back:
  - Exactly 3 `cs` pulses, with `sel_eu` sequence 01, 10, 00.
  - One `illegal` pulse between them.
  - `ir_ready`=0 while `count`=4.
- Fill to DEPTH, push again with `ir_valid`=1:
  - The extra word is not stored.
  - Push coincident with retire leaves `count` unchanged.
  - Wrap-around over 10 words preserves order.
- Hold `eu_ready`=1 after `cs`:
  - `err` pulses after 4 WAIT_BUSY cycles.
  - The entry is dropped and the next entry issues.
- Queue 3 words, assert `flush` during WAIT_DONE:
  - The in-flight word completes.
  - `count`=1 then 0.
  - No further `cs`.
- Assert `rst` in WAIT_DONE with 2 entries queued:
  - Next cycle: `count`=0, `busy`=0, `cs`=0.
  - No issue follows.
